// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, multi-read register file with bypass and busy scoreboard
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [DW-1:0]        wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [DW-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic                 wr_conflict
);
    localparam int DEPTH = 1 << AW;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy, clr, set;
    logic             e0, e1;
    assign e0  = we0 & ena & ~((ZERO_REG != 0) & (waddr0 == '0));
    assign e1  = we1 & ena & ~((ZERO_REG != 0) & (waddr1 == '0));
    assign clr = (DEPTH'(e0) << waddr0) | (DEPTH'(e1) << waddr1);
    assign set = DEPTH'(busy_set & ena & ~((ZERO_REG != 0) & (busy_addr == '0))) << busy_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy        <= '0;
            wr_conflict <= 1'b0;
        end else begin
            // port 1 is written last so it wins on a same-address collision
            if (e0) mem[waddr0] <= wdata0;
            if (e1) mem[waddr1] <= wdata1;
            busy        <= (busy & ~clr) | set;
            wr_conflict <= e0 & e1 & (waddr0 == waddr1);
        end
    end
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          m0, m1, z;
        assign ra = raddr[g*AW +: AW];
        assign m0 = (BYPASS != 0) & e0 & (waddr0 == ra);
        assign m1 = (BYPASS != 0) & e1 & (waddr1 == ra);
        assign z  = ~ena | ((ZERO_REG != 0) & (ra == '0));
        assign rdata[g*DW +: DW] = z ? '0 : m1 ? wdata1 : m0 ? wdata0 : mem[ra];
        assign rd_busy[g]        = ~z & ~m0 & ~m1 & busy[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based model
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n, ena, we0, we1, busy_set;
    logic [4:0]  waddr0, waddr1, busy_addr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rd_busy;
    logic        wr_conflict;
    logic [31:0] ref_mem [32];
    logic        ref_busy [32];
    logic        ref_conf;
    int          checks = 0;
    int          errors = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .busy_set(busy_set), .busy_addr(busy_addr), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // what a read of register a should show right now, forwarding included
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!ena || a == 0) return 32'h0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!ena || a == 0) return 1'b0;
        if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
        return ref_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = 32'h0;
            ref_busy[i] = 1'b0;
        end
        ref_conf = 1'b0;
    endtask

    task automatic model_edge();
        if (ena) begin
            ref_conf = we0 && we1 && waddr0 == waddr1 && waddr0 != 0;
            if (we0 && waddr0 != 0) begin ref_mem[waddr0] = wdata0; ref_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin ref_mem[waddr1] = wdata1; ref_busy[waddr1] = 1'b0; end
            if (busy_set && busy_addr != 0) ref_busy[busy_addr] = 1'b1;
        end else begin
            ref_conf = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_rdata"}, 64'(rdata[i*32 +: 32]), 64'(exp_rd(raddr[i*5 +: 5])));
            chk({tag, "_rd_busy"}, 64'(rd_busy[i]), 64'(exp_busy(raddr[i*5 +: 5])));
        end
        chk({tag, "_wr_conflict"}, 64'(wr_conflict), 64'(ref_conf));
    endtask

    // inputs are set just after a falling edge; check, then cross one rising edge
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1'b1; we0 = 1'b0; we1 = 1'b0; busy_set = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; busy_addr = '0; raddr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle("init");

        for (int n = 0; n < 400; n++) begin
            ena       = ($urandom % 8) != 0;
            we0       = $urandom % 2;
            we1       = $urandom % 2;
            busy_set  = ($urandom % 3) == 0;
            waddr0    = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            waddr1    = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            busy_addr = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            raddr     = ($urandom % 2) ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))} : 10'($urandom);
            wdata0    = $urandom;
            wdata1    = $urandom;
            cycle("rand");
        end

        idle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        cycle("basic_wr");
        idle();
        raddr = {5'd5, 5'd0};
        #1 chk("basic_rd", 64'(rdata[63:32]), 64'h0000_0000_DEAD_BEEF);
        cycle("basic_rd");
        ena = 1'b0;
        #1 chk("ena_off", 64'(rdata), 64'h0);
        cycle("ena_off");

        idle();
        we0 = 1'b1; we1 = 1'b1; wdata0 = 32'h12345678; wdata1 = 32'h12345678; busy_set = 1'b1;
        cycle("zero_wr");
        idle();
        #1 chk("zero_rd", 64'(rdata[31:0]), 64'h0);
        chk("zero_busy", 64'(rd_busy[0]), 64'h0);
        chk("zero_conf", 64'(wr_conflict), 64'h0);
        cycle("zero_rd");

        idle();
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7; wdata0 = 32'h1111; wdata1 = 32'h2222;
        cycle("coll_wr");
        idle();
        raddr = {5'd0, 5'd7};
        #1 chk("coll_conf", 64'(wr_conflict), 64'h1);
        chk("coll_rd", 64'(rdata[31:0]), 64'h2222);
        cycle("coll_rd");
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd3; waddr1 = 5'd4; wdata0 = 32'h3333; wdata1 = 32'h4444;
        #1 chk("coll_conf_drop", 64'(wr_conflict), 64'h0);
        cycle("diff_wr");
        idle();
        raddr = {5'd4, 5'd3};
        #1 chk("diff_rd", 64'(rdata), {32'h4444, 32'h3333});
        chk("diff_conf", 64'(wr_conflict), 64'h0);
        cycle("diff_rd");

        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5; raddr = {5'd0, 5'd9};
        #1 chk("bypass", 64'(rdata[31:0]), 64'hA5A5_A5A5);
        cycle("bypass");

        idle();
        busy_set = 1'b1; busy_addr = 5'd12; raddr = {5'd0, 5'd12};
        #1 chk("sb_set_same", 64'(rd_busy[0]), 64'h0);
        cycle("sb_set");
        idle();
        raddr = {5'd0, 5'd12};
        #1 chk("sb_busy", 64'(rd_busy[0]), 64'h1);
        cycle("sb_busy");
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hC0FFEE;
        #1 chk("sb_wb_mask", 64'(rd_busy[0]), 64'h0);
        cycle("sb_wb");
        idle();
        raddr = {5'd0, 5'd12};
        #1 chk("sb_clear", 64'(rd_busy[0]), 64'h0);
        cycle("sb_clear");
        busy_set = 1'b1; busy_addr = 5'd12; we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hBEEF;
        cycle("sb_set_wb");
        idle();
        raddr = {5'd0, 5'd12};
        #1 chk("sb_set_wins", 64'(rd_busy[0]), 64'h1);
        cycle("sb_set_wins");

        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd20; waddr1 = 5'd20; wdata0 = 32'h5; wdata1 = 32'h6;
        cycle("pre_rst");
        idle();
        we0 = 1'b1; waddr0 = 5'd21; wdata0 = 32'hFFFF_0000; busy_set = 1'b1; busy_addr = 5'd22;
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("rst_conf", 64'(wr_conflict), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 16; i++) begin
            raddr = {5'(2 * i + 1), 5'(2 * i)};
            #1 chk("rst_rd", {30'h0, rd_busy, rdata[63:32] | rdata[31:0]}, 64'h0);
            cycle("rst_rd");
        end
        we0 = 1'b1; waddr0 = 5'd21; wdata0 = 32'h0BAD_F00D;
        cycle("post_rst_wr");
        idle();
        raddr = {5'd21, 5'd0};
        #1 chk("post_rst_rd", 64'(rdata[63:32]), 64'h0BAD_F00D);
        cycle("post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Generalised in data width, depth and read-port count; adds a second write port with a fixed priority rule, optional write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers (MUL/DIV, loads).
- Sits in the CPU datapath between decode (read addresses, busy issue) and writeback (two result buses).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports and busy lookups; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and busy sets; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; gates writes, busy updates and read outputs.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- raddr  in  NUM_RD*AW  read addresses; port i is bits [i*AW +: AW].
- rdata  out  NUM_RD*DW  read data; port i is bits [i*DW +: DW].
- rd_busy  out  NUM_RD  bit i = register at raddr port i has a pending producer.
- busy_set  in  1  mark waddr-to-be as busy (producer issued).
- busy_addr  in  AW  register to mark busy.
- wr_conflict  out  1  registered flag: in the previous cycle both ports wrote the same effective register.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, wr_conflict = 0.
  - Reset asserted mid-operation discards any in-flight write or busy update of that cycle.
  - On release, the first rising edge with ena=1 performs normal updates.
- Effective write for port k: wek & ena & !(ZERO_REG & waddrk==0).
- Writes occur at the rising edge.
  - Both ports effective on the same address: port 1 data is stored (port 1 wins); otherwise both writes happen.
- Reads are combinational, no latency.
  - ena=0: every rdata slice = 0 and rd_busy = 0 (no high-Z on internal buses).
  - ZERO_REG=1 and raddr=0: rdata = 0 and rd_busy = 0 regardless of array contents.
- Bypass (BYPASS=1): if an effective write matches raddr port i in the same cycle, rdata port i = that write's data.
  - If both ports match, port 1 data is forwarded.
  - BYPASS=0: rdata reflects the array only; the new value is visible the cycle after the edge.
- Scoreboard, one busy bit per register, updated at the rising edge when ena=1:
  - set when busy_set=1 and the address is not reg 0 (reg 0 excluded when ZERO_REG=1);
  - cleared by any effective write to that address on either port;
  - set and clear on the same address in the same cycle: set wins, because the new producer supersedes the retiring one.
- rd_busy i = busy[raddr i].
  - BYPASS=1: a same-cycle effective write to that address masks the busy bit to 0, because the data is forwarded.
  - A same-cycle busy_set to the same address does not raise rd_busy until the next cycle.
- wr_conflict is registered: 1 for exactly the cycle after both ports made effective writes to the same address; 0 otherwise.
- Address arithmetic is plain AW-bit indexing; there is no wrap-around or out-of-range case.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with we0=1 -> all 32 regs read 0, rd_busy=0, wr_conflict=0; the pending write is not stored.
- Basic write/read: we0=1, waddr0=5, wdata0=0xDEADBEEF -> next cycle raddr port 1=5 returns 0xDEADBEEF; ena=0 -> rdata=0.
- Zero register: write 0x12345678 to reg 0 via both ports plus busy_set on 0 -> reg 0 reads 0, rd_busy=0, wr_conflict stays 0.
- Dual-write collision: we0/we1 on reg 7 with 0x1111/0x2222 -> reg 7 = 0x2222, wr_conflict=1 for exactly one cycle.
  - Different addresses 3 and 4 -> both stored, wr_conflict=0.
- Bypass: same-cycle write 0xA5A5A5A5 to reg 9 with raddr0=9 -> rdata0=0xA5A5A5A5 combinationally (BYPASS=1); old value shown (BYPASS=0).
- Scoreboard: busy_set reg 12 -> rd_busy=1 next cycle; writeback reg 12 -> rd_busy=0 in that cycle (BYPASS=1), bit clear after the edge.
  - busy_set and writeback on reg 12 in the same cycle -> bit remains 1.
